// File: rtl/sram_pkg.sv
// Shared types and constants for the 32-bit word to 16-bit async SRAM bridge.
package sram_pkg;

    localparam int SRAM_DATA_W         = 16;
    localparam int SRAM_ADDR_W         = 18;
    localparam int DEFAULT_BASE_ADDR   = 1024;
    localparam int DEFAULT_WAIT_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_LO = 3'd1,
        WR_HI = 3'd2,
        RD_LO = 3'd3,
        RD_HI = 3'd4,
        DONE  = 3'd5
    } sram_state_e;

endpackage

// File: rtl/sram_wait_counter.sv
// Phase timer: counts cycles spent in the current halfword phase and flags
// the final one, both for the current cycle and for the cycle about to start.
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    output logic o_last,
    output logic o_last_next
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;

    // Loading restarts the phase at zero; the FSM loads on every phase change.
    assign w_count_next = i_load ? '0 : (r_count + CW'(1));
    assign o_last       = (r_count == LAST_COUNT);
    assign o_last_next  = (w_count_next == LAST_COUNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

endmodule

// File: rtl/sram_controller.sv
// Splits 32-bit load/store requests into two 16-bit async SRAM phases
// (low half first) and freezes the pipeline while the access is in flight.
module sram_controller
    import sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'(DEFAULT_BASE_ADDR),
    parameter int          WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   readEnabled,
    input  logic                   writeEnabled,
    input  logic [31:0]            address,
    input  logic [31:0]            writeData,
    output logic [31:0]            readData,
    output logic                   freeze,
    inout  wire  [SRAM_DATA_W-1:0] SRAMData,
    output logic [SRAM_ADDR_W-1:0] SRAMAddress,
    output logic                   SRAMUB,
    output logic                   SRAMLB,
    output logic                   SRAMWE,
    output logic                   SRAMOE,
    output logic                   SRAMCE
);

    sram_state_e r_state;
    sram_state_e w_state_next;

    logic [SRAM_ADDR_W-1:0] r_addr;
    logic [SRAM_DATA_W-1:0] r_wdata;
    logic                   r_drive_en;
    logic                   r_we_n;
    logic                   r_oe_n;
    logic [31:0]            r_read_data;

    logic        w_req;
    logic        w_load;
    logic        w_last;
    logic        w_last_next;
    logic        w_is_wr_next;
    logic        w_is_rd_next;
    logic        w_hi_next;
    logic [31:0] w_off;
    logic        w_unused_off_bits;

    assign w_req = readEnabled | writeEnabled;

    // Offset wraps modulo 2^32; out-of-window addresses simply alias.
    assign w_off             = address - BASE_ADDR;
    assign w_unused_off_bits = ^{w_off[31:19], w_off[1:0]};

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk         (clk),
        .rst_n       (rst),
        .i_load      (w_load),
        .o_last      (w_last),
        .o_last_next (w_last_next)
    );

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b1;
        case (r_state)
            IDLE: begin
                if (writeEnabled) begin
                    w_state_next = WR_LO;
                end else if (readEnabled) begin
                    w_state_next = RD_LO;
                end
            end
            WR_LO, WR_HI, RD_LO, RD_HI: begin
                if (!w_req) begin
                    w_state_next = IDLE;
                end else if (w_last) begin
                    case (r_state)
                        WR_LO:   w_state_next = WR_HI;
                        RD_LO:   w_state_next = RD_HI;
                        default: w_state_next = DONE;
                    endcase
                end else begin
                    w_load = 1'b0;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_is_wr_next = (w_state_next == WR_LO) || (w_state_next == WR_HI);
    assign w_is_rd_next = (w_state_next == RD_LO) || (w_state_next == RD_HI);
    assign w_hi_next    = (w_state_next == WR_HI) || (w_state_next == RD_HI);

    // Pin registers are computed from the upcoming state so they are stable
    // for the whole phase; WE rises early in the final cycle for hold margin.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_drive_en  <= 1'b0;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_read_data <= '0;
        end else begin
            r_state    <= w_state_next;
            r_drive_en <= w_is_wr_next;
            r_we_n     <= !(w_is_wr_next && ((WAIT_CYCLES == 1) || !w_last_next));
            r_oe_n     <= !w_is_rd_next;
            if (w_is_wr_next || w_is_rd_next) begin
                r_addr <= {w_off[18:2], w_hi_next};
            end
            if (w_is_wr_next) begin
                r_wdata <= w_hi_next ? writeData[31:16] : writeData[15:0];
            end
            if ((r_state == RD_LO) && w_last && w_req) begin
                r_read_data[15:0] <= SRAMData;
            end
            if ((r_state == RD_HI) && w_last && w_req) begin
                r_read_data[31:16] <= SRAMData;
            end
        end
    end

    assign SRAMData    = r_drive_en ? r_wdata : {SRAM_DATA_W{1'bz}};
    assign SRAMAddress = r_addr;
    assign SRAMWE      = r_we_n;
    assign SRAMOE      = r_oe_n;
    assign SRAMUB      = 1'b0;
    assign SRAMLB      = 1'b0;
    assign SRAMCE      = 1'b0;
    assign readData    = r_read_data;
    assign freeze      = w_req & (r_state != DONE) & rst;

endmodule
